// File: rtl/dwbuart_pkg.sv
// -----------------------------------------------------------------------------
// dwbuart_pkg
// Shared types for the UART datapath.
//   rx_entry_t      : one buffered RX entry {fe, pe, data[7:0]} (10 bits)
//   rx_ctrl_state_t : receive sequencer states
//   rx_extract_data : pulls the data byte out of an aligned frame
// -----------------------------------------------------------------------------
package dwbuart_pkg;

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rx_ctrl_state_t;

  // Bit 0 of the frame is the first data bit. In 7-bit mode, bit 7 is the
  // parity or stop bit and must not leak into the data byte.
  function automatic logic [7:0] rx_extract_data(input logic [10:0] frame,
                                                 input logic        ds8);
    logic [7:0] d;
    if (ds8) begin
      d = frame[7:0];
    end else begin
      d = {1'b0, frame[6:0]};
    end
    return d;
  endfunction

endpackage

// File: rtl/rx_controller_if.sv
// -----------------------------------------------------------------------------
// rx_controller_if
// Bundles the frontend, configuration and register-file signals of the RX
// controller.
//   modport master : the surrounding system (frontend + register file); drives
//                    configuration, frames, pop/flush/clear requests and
//                    observes the status/head outputs.
//   modport slave  : the rx_controller itself.
// Signal names keep the controller-relative _i/_o suffixes.
// -----------------------------------------------------------------------------
interface rx_controller_if #(
  parameter int LEVEL_W = 4
) ();

  // configuration
  logic               cr_en_i;
  logic               cr_ds_i;
  logic [LEVEL_W-1:0] cr_rxth_i;
  // register-file requests
  logic               flush_i;
  logic               pop_i;
  logic               or_clr_i;
  // frontend
  logic [10:0]        frame_i;
  logic               parity_err_i;
  logic               frame_err_i;
  logic               frame_valid_i;
  // head entry and status
  logic [7:0]         data_o;
  logic               pe_o;
  logic               fe_o;
  logic               rxne_o;
  logic               or_o;
  logic [LEVEL_W-1:0] level_o;
  logic               irq_o;

  modport master (
    output cr_en_i, cr_ds_i, cr_rxth_i, flush_i, pop_i, or_clr_i,
           frame_i, parity_err_i, frame_err_i, frame_valid_i,
    input  data_o, pe_o, fe_o, rxne_o, or_o, level_o, irq_o
  );

  modport slave (
    input  cr_en_i, cr_ds_i, cr_rxth_i, flush_i, pop_i, or_clr_i,
           frame_i, parity_err_i, frame_err_i, frame_valid_i,
    output data_o, pe_o, fe_o, rxne_o, or_o, level_o, irq_o
  );

endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write wdata_i; accepted when not full, or when full and a
//                  pop is accepted in the same cycle
//   pop_i        : remove the head; ignored while empty
//   flush_i      : empty the FIFO (overrides push/pop in that cycle)
//   wdata_i      : write data
//   head_o       : current head entry (undefined content while empty)
//   full_o, empty_o, level_o : occupancy status, level_o in 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO can still accept a write when the head leaves in the same
  // cycle: the freed slot is the one the write pointer lands on.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: stale slots are never visible because the
  // pointers and level are cleared.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/rx_controller.sv
// -----------------------------------------------------------------------------
// rx_controller
// Sequences the UART receive path: captures completed frames from the
// frontend, extracts the data byte for the live data size, tags it with the
// parity/framing error flags and buffers it in an RX FIFO. Drives RXNE,
// sticky overrun and the threshold interrupt; services pop/flush/clear.
//   clk_i : system clock
//   rst_i : synchronous active-high reset
//   bus   : rx_controller_if.slave
//             inputs : cr_en_i, cr_ds_i, cr_rxth_i, flush_i, pop_i, or_clr_i,
//                      frame_i, parity_err_i, frame_err_i, frame_valid_i
//             outputs: data_o, pe_o, fe_o (head entry, 0 when empty),
//                      rxne_o, or_o, level_o, irq_o
// -----------------------------------------------------------------------------
module rx_controller
  import dwbuart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
  input logic            clk_i,
  input logic            rst_i,
  rx_controller_if.slave bus
);

  rx_ctrl_state_t     state_q, state_d;
  logic               or_q, or_d;

  logic               capture;
  logic               flush_fifo;
  logic               overrun;
  rx_entry_t          new_entry;
  rx_entry_t          head_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;

  // Bits above the 8-bit data field carry parity/stop and are already
  // digested by the frontend into the error flags.
  logic               unused_frame_hi;
  assign unused_frame_hi = ^bus.frame_i[10:8];

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    flush_fifo = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A flush request while idle is serviced on the spot.
        flush_fifo = bus.flush_i;
        if (bus.cr_en_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        capture = bus.frame_valid_i;
        // Disabling takes priority over a flush request.
        if (!bus.cr_en_i) begin
          state_d = IDLE;
        end else if (bus.flush_i) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        flush_fifo = 1'b1;
        state_d    = bus.cr_en_i ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry extraction and buffering
  // ---------------------------------------------------------------------------
  always_comb begin
    new_entry      = '0;
    new_entry.fe   = bus.frame_err_i;
    new_entry.pe   = bus.parity_err_i;
    new_entry.data = rx_extract_data(bus.frame_i, bus.cr_ds_i);
  end

  sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (capture),
    .pop_i   (bus.pop_i),
    .flush_i (flush_fifo),
    .wdata_i (new_entry),
    .head_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // ---------------------------------------------------------------------------
  // Overrun: a capture into a full FIFO with no simultaneous pop is lost.
  // The FIFO itself refuses the write; here we only record the loss.
  // ---------------------------------------------------------------------------
  assign overrun = capture && fifo_full && !bus.pop_i;

  always_comb begin
    or_d = or_q;
    if (overrun) begin
      or_d = 1'b1;               // set beats a same-cycle clear
    end else if (bus.or_clr_i) begin
      or_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      or_q <= 1'b0;
    end else begin
      or_q <= or_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rxne_o  = !fifo_empty;
  assign bus.level_o = fifo_level;
  assign bus.or_o    = or_q;
  assign bus.data_o  = fifo_empty ? 8'h00 : head_entry.data;
  assign bus.pe_o    = fifo_empty ? 1'b0  : head_entry.pe;
  assign bus.fe_o    = fifo_empty ? 1'b0  : head_entry.fe;
  assign bus.irq_o   = (bus.cr_rxth_i != '0) && (fifo_level >= bus.cr_rxth_i);

endmodule

// File: doc/rx_controller.md
Name: rx_controller

Overview:
- Sequences the UART receive path between the receive frontend and the Wishbone register file.
- Captures each completed frame from the frontend and extracts the data byte according to the live configuration.
- Tags each byte with its parity and framing error flags and buffers it in an RX FIFO.
- Drives the RX status flags (RXNE, overrun, threshold interrupt) and services pop and flush requests from the register interface.

Parameters:
- FIFO_DEPTH, 8, number of RX entries; power of two, minimum 2.
- LEVEL_W, $clog2(FIFO_DEPTH)+1, width of the FIFO level counter.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- cr_en_i  in  1  receiver enable; when 0, incoming frames are dropped.
- cr_ds_i  in  1  data size: 1 = 8 data bits, 0 = 7 data bits.
- cr_rxth_i  in  LEVEL_W  RX threshold level for the interrupt.
- flush_i  in  1  one-cycle request to empty the FIFO.
- frame_i  in  11  aligned frame; bit0 = first data bit (LSB), start bit excluded.
- parity_err_i  in  1  frontend parity error, already masked when parity is disabled.
- frame_err_i  in  1  frontend stop-bit error.
- frame_valid_i  in  1  one-cycle pulse; frame_i and the error inputs are valid in that cycle.
- pop_i  in  1  register-read pop of the head entry.
- or_clr_i  in  1  clears the sticky overrun flag.
- data_o  out  8  head data byte (first-word-fall-through).
- pe_o  out  1  head entry parity error.
- fe_o  out  1  head entry framing error.
- rxne_o  out  1  FIFO not empty.
- or_o  out  1  sticky overrun flag.
- level_o  out  LEVEL_W  number of valid entries.
- irq_o  out  1  asserted when level_o >= cr_rxth_i and cr_rxth_i != 0.

Behaviour:
- Reset (synchronous, rst_i=1): state=IDLE, FIFO empty, level_o=0, rxne_o=0, or_o=0, irq_o=0, data_o=0, pe_o=0, fe_o=0.
- Reset mid-operation discards all stored entries and any capture in progress.
- State machine:
  - IDLE: cr_en_i=1 -> RUN. Frames received in IDLE are dropped and do not set or_o.
  - RUN: cr_en_i=0 -> IDLE. flush_i=1 -> FLUSH.
  - FLUSH: lasts exactly one cycle, during which the FIFO is emptied. Goes to RUN if cr_en_i=1, else IDLE. frame_valid_i during FLUSH is dropped.
  - flush_i in IDLE also empties the FIFO in that same cycle; the state stays IDLE.
- Capture: frame_valid_i in RUN at edge N builds an entry = {fe, pe, data}.
  - data = frame_i[7:0] when cr_ds_i=1.
  - data = {1'b0, frame_i[6:0]} when cr_ds_i=0.
  - The entry is written at edge N. rxne_o and level_o reflect it from cycle N+1. Latency is 1 cycle.
- Pop: pop_i with rxne_o=1 removes the head at the edge. pop_i while empty is ignored; level_o stays 0 and there is no underflow.
- Full FIFO:
  - A push while full and no pop drops the frame and sets or_o at that edge. FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both succeed, level is unchanged, or_o is not set.
- Push and pop in the same cycle while level=1: the head advances to the new entry and level stays 1.
- or_o is sticky until or_clr_i=1.
  - If or_clr_i and a new overrun occur in the same cycle, the set wins and or_o=1.
  - Flush does not clear or_o.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. level_o ranges 0..FIFO_DEPTH.
- data_o, pe_o and fe_o are driven from the head entry when rxne_o=1 and forced to 0 when empty.
- irq_o is combinational from the registered level_o and cr_rxth_i.
- Changing cr_ds_i affects only frames captured after the change; stored entries are not reinterpreted.

Decomposition:
- Package dwbuart_pkg holds:
  - typedef rx_entry_t, packed {fe, pe, data[7:0]} (10 bits);
  - enum rx_ctrl_state_t {IDLE, RUN, FLUSH}.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH), provides:
  - push, pop, flush, full, empty, level, and a first-word-fall-through head output.
  - It is reused later by the TX path.
- rx_controller contains the state machine, entry extraction, overrun logic and irq.

Test Plan:
- Enable with cr_ds_i=1; pulse frame_valid_i with frame_i=11'h4A5 and no errors -> next cycle rxne_o=1, data_o=8'hA5, pe_o=0, fe_o=0, level_o=1; pop_i -> rxne_o=0.
- cr_ds_i=0, frame_i=11'h0FF, parity_err_i=1 -> data_o=8'h7F, pe_o=1.
- Push 8 frames (0x01..0x08) with FIFO_DEPTH=8, then push 0x09 -> level_o=8, or_o=1; pops return 0x01..0x08 in order; or_clr_i -> or_o=0.
- With level_o=8, push and pop in the same cycle -> level_o=8, or_o=0, head=0x02, tail=new byte.
- cr_rxth_i=3: push 3 frames -> irq_o=1 after the third; one pop -> irq_o=0. flush_i -> level_o=0, rxne_o=0, or_o unchanged.
- cr_en_i=0, frame_valid_i pulse -> level_o stays 0, or_o=0. Assert rst_i with 4 entries stored -> all outputs 0 on the next cycle.
